// File: rtl/direct_mapped_cache_ctrl_if.sv
// ----------------------------------------------------------------------------
// direct_mapped_cache_ctrl_if
// Purpose : groups the CPU request/response handshake and the memory-side
//           control signals of the direct-mapped cache controller.
// Signals :
//   cpu_req, cpu_we, cpu_addr, cpu_wdata   CPU request (master -> slave)
//   cpu_rdata, cpu_ready, cpu_busy         CPU response (slave -> master)
//   rd_mem, wr_mem, addr_mem               memory commands (slave -> master)
//   ready_mem                              memory idle flag (master -> slave)
//   hit_count, miss_count                  lookup statistics, only present
//                                          when CACHE_STATS_EN is defined
// Modports: slave = cache controller, master = CPU/memory environment.
// ----------------------------------------------------------------------------
interface direct_mapped_cache_ctrl_if #(
   parameter int unsigned AWIDTH = 9,
   parameter int unsigned DWIDTH = 8
);
   logic              cpu_req;
   logic              cpu_we;
   logic [AWIDTH-1:0] cpu_addr;
   logic [DWIDTH-1:0] cpu_wdata;
   logic [DWIDTH-1:0] cpu_rdata;
   logic              cpu_ready;
   logic              cpu_busy;
   logic              rd_mem;
   logic              wr_mem;
   logic [AWIDTH-1:0] addr_mem;
   logic              ready_mem;
`ifdef CACHE_STATS_EN
   logic [15:0]       hit_count;
   logic [15:0]       miss_count;
`endif

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ready_mem,
      output cpu_rdata, cpu_ready, cpu_busy, rd_mem, wr_mem, addr_mem
`ifdef CACHE_STATS_EN
      , output hit_count, miss_count
`endif
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, ready_mem,
      input  cpu_rdata, cpu_ready, cpu_busy, rd_mem, wr_mem, addr_mem
`ifdef CACHE_STATS_EN
      , input hit_count, miss_count
`endif
   );
endinterface

// File: rtl/direct_mapped_cache_ctrl.sv
// ----------------------------------------------------------------------------
// direct_mapped_cache_ctrl
// Purpose : direct-mapped, write-through, no-write-allocate cache controller
//           with one data word per line. Read hits complete without memory
//           traffic; read misses fetch and allocate; every write goes to
//           memory and updates the line only on a hit.
// Ports   :
//   clk       in     clock, all state on posedge
//   reset_n   in     synchronous active-low reset
//   bus       slave  CPU handshake + memory command signals (see _if file)
//   mem_data  inout  memory data bus, driven only while wr_mem=1
// Optional: define CACHE_STATS_EN to add saturating hit_count/miss_count.
// ----------------------------------------------------------------------------
module direct_mapped_cache_ctrl #(
   parameter int unsigned AWIDTH     = 9,
   parameter int unsigned DWIDTH     = 8,
   parameter int unsigned IDX_W      = 4,
   parameter int unsigned MEM_RD_CYC = 2
) (
   input  logic                       clk,
   input  logic                       reset_n,
   direct_mapped_cache_ctrl_if.slave  bus,
   inout  wire  [DWIDTH-1:0]          mem_data
);

   localparam int unsigned NUM_LINES = 2 ** IDX_W;
   localparam int unsigned TAG_W     = AWIDTH - IDX_W;
   localparam int unsigned CNT_W     = (MEM_RD_CYC > 2) ? $clog2(MEM_RD_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_MEM_RD = 2'd2,
      ST_MEM_WR = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   // latched request
   logic [AWIDTH-1:0]   r_addr;
   logic                r_we;
   logic [DWIDTH-1:0]   r_wdata;

   // output registers
   logic [DWIDTH-1:0]   r_cpu_rdata;
   logic                r_cpu_ready;
   logic                r_rd_mem;
   logic                r_wr_mem;
   logic [AWIDTH-1:0]   r_addr_mem;
   logic [CNT_W-1:0]    r_cnt;

   // cache array
   logic [NUM_LINES-1:0] r_valid;
   logic [TAG_W-1:0]     r_tag  [NUM_LINES];
   logic [DWIDTH-1:0]    r_line [NUM_LINES];

   // FSM strobes
   logic                w_accept;
   logic                w_rd_hit;
   logic                w_start_rd;
   logic                w_start_wr;
   logic                w_cnt_inc;
   logic                w_rd_done;
   logic                w_wr_done;
   logic                w_line_wr;
   logic                w_lookup_done;

   logic [IDX_W-1:0]    w_index;
   logic [TAG_W-1:0]    w_tag;
   logic                w_hit;

   assign w_index = r_addr[IDX_W-1:0];
   assign w_tag   = r_addr[AWIDTH-1:IDX_W];
   assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and strobe decode
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_rd_hit    = 1'b0;
      w_start_rd  = 1'b0;
      w_start_wr  = 1'b0;
      w_cnt_inc   = 1'b0;
      w_rd_done   = 1'b0;
      w_wr_done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.cpu_req) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            // read hits never wait on memory; everything else needs the bus
            if (!r_we && w_hit) begin
               w_rd_hit    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (bus.ready_mem) begin
               if (r_we) begin
                  w_start_wr  = 1'b1;
                  w_state_nxt = ST_MEM_WR;
               end else begin
                  w_start_rd  = 1'b1;
                  w_state_nxt = ST_MEM_RD;
               end
            end
         end
         ST_MEM_RD: begin
            if (r_cnt == CNT_LAST) begin
               w_rd_done   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_inc   = 1'b1;
            end
         end
         ST_MEM_WR: begin
            w_wr_done   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_line_wr     = w_start_wr && w_hit;
   assign w_lookup_done = w_rd_hit || w_start_rd || w_start_wr;

   // Request latch, output registers and valid bits
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_cpu_rdata <= '0;
         r_cpu_ready <= 1'b0;
         r_rd_mem    <= 1'b0;
         r_wr_mem    <= 1'b0;
         r_addr_mem  <= '0;
         r_cnt       <= '0;
         r_valid     <= '0;
      end else begin
         r_cpu_ready <= 1'b0;
         if (w_accept) begin
            r_addr  <= bus.cpu_addr;
            r_we    <= bus.cpu_we;
            r_wdata <= bus.cpu_wdata;
         end
         if (w_rd_hit) begin
            r_cpu_rdata <= r_line[w_index];
            r_cpu_ready <= 1'b1;
         end
         if (w_start_rd) begin
            r_addr_mem <= r_addr;
            r_rd_mem   <= 1'b1;
            r_cnt      <= '0;
         end
         if (w_start_wr) begin
            r_addr_mem <= r_addr;
            r_wr_mem   <= 1'b1;
         end
         if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_rd_done) begin
            r_valid[w_index] <= 1'b1;
            r_cpu_rdata      <= mem_data;
            r_cpu_ready      <= 1'b1;
            r_rd_mem         <= 1'b0;
         end
         if (w_wr_done) begin
            r_wr_mem    <= 1'b0;
            r_cpu_ready <= 1'b1;
         end
      end
   end

   // Tag/data array; contents are meaningless while the valid bit is clear
   always_ff @(posedge clk) begin
      if (w_line_wr) begin
         r_line[w_index] <= r_wdata;
      end
      if (w_rd_done) begin
         r_line[w_index] <= mem_data;
         r_tag[w_index]  <= w_tag;
      end
   end

   assign mem_data      = r_wr_mem ? r_wdata : {DWIDTH{1'bz}};
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.cpu_ready = r_cpu_ready;
   assign bus.cpu_busy  = (r_state != ST_IDLE);
   assign bus.rd_mem    = r_rd_mem;
   assign bus.wr_mem    = r_wr_mem;
   assign bus.addr_mem  = r_addr_mem;

`ifdef CACHE_STATS_EN
   logic [15:0] r_hit_count;
   logic [15:0] r_miss_count;

   // One count per lookup that leaves LOOKUP; stalls are not recounted
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_hit_count  <= '0;
         r_miss_count <= '0;
      end else if (w_lookup_done) begin
         if (w_hit) begin
            if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
         end else begin
            if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
         end
      end
   end

   assign bus.hit_count  = r_hit_count;
   assign bus.miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_direct_mapped_cache_ctrl.sv
// ----------------------------------------------------------------------------
// tb_direct_mapped_cache_ctrl
// Purpose : self-checking bench for direct_mapped_cache_ctrl. A memory model
//           serves the bidirectional bus; a transaction-level cache/memory
//           reference predicts hit/miss, per-cycle strobes and read data.
// ----------------------------------------------------------------------------
module tb_direct_mapped_cache_ctrl;

   localparam int unsigned AW    = 9;
   localparam int unsigned DW    = 8;
   localparam int unsigned IW    = 4;
   localparam int unsigned RDC   = 2;
   localparam int unsigned NL    = 16;
   localparam int unsigned MEMSZ = 512;

   logic clk = 1'b0;
   logic reset_n;
   wire  [DW-1:0] mem_bus;

   always #5 clk = ~clk;

   direct_mapped_cache_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) ifc ();

   direct_mapped_cache_ctrl #(
      .AWIDTH(AW), .DWIDTH(DW), .IDX_W(IW), .MEM_RD_CYC(RDC)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (ifc),
      .mem_data (mem_bus)
   );

   // ---------------- memory model ----------------
   logic [DW-1:0]    tb_mem [MEMSZ];
   logic [MEMSZ-1:0] tb_wflag = '0;
   logic [DW-1:0]    mem_rd_val;

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      logic [15:0] t;
      if (a == 9'h123) return 8'hA5;
      t = 16'(a) * 16'd37 + 16'd11;
      return t[7:0];
   endfunction

   always_comb mem_rd_val = tb_wflag[ifc.addr_mem] ? tb_mem[ifc.addr_mem] : init_val(ifc.addr_mem);
   assign mem_bus = ifc.rd_mem ? mem_rd_val : {DW{1'bz}};

   always @(posedge clk) begin
      if (ifc.wr_mem) begin
         tb_mem[ifc.addr_mem]   <= mem_bus;
         tb_wflag[ifc.addr_mem] <= 1'b1;
      end
   end

   // ---------------- reference model ----------------
   logic          ref_valid [NL];
   int unsigned   ref_tag   [NL];
   logic [DW-1:0] ref_data  [NL];
   logic [DW-1:0] ref_mem   [MEMSZ];
   int            ref_hits;
   int            ref_misses;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic ref_invalidate();
      for (int i = 0; i < int'(NL); i++) ref_valid[i] = 1'b0;
      ref_hits   = 0;
      ref_misses = 0;
   endtask

   // One CPU transaction; s = number of LOOKUP edges that see ready_mem=0
   task automatic do_access(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input int s);
      int unsigned idx, tg;
      logic hit, rd_miss;
      int exp_lat;
      logic [DW-1:0] exp_rd;
      idx     = int'(addr) % NL;
      tg      = int'(addr) / NL;
      hit     = ref_valid[idx] && (ref_tag[idx] == tg);
      rd_miss = !we && !hit;
      exp_lat = (!we && hit) ? 1 : (we ? s + 2 : s + 1 + int'(RDC));
      exp_rd  = hit ? ref_data[idx] : ref_mem[addr];

      ifc.cpu_req   = 1'b1;
      ifc.cpu_we    = we;
      ifc.cpu_addr  = addr;
      ifc.cpu_wdata = wdata;
      @(posedge clk); #1;
      // garbage on the request lines must not leak into the latched request
      ifc.cpu_req   = 1'b0;
      ifc.cpu_we    = 1'($urandom);
      ifc.cpu_addr  = AW'($urandom);
      ifc.cpu_wdata = DW'($urandom);
      ifc.ready_mem = (s < 1);
      for (int n = 0; n <= exp_lat + 1; n++) begin
         if (n > 0) begin
            @(posedge clk); #1;
            ifc.ready_mem = (n + 1 > s);
         end
         @(negedge clk);
         chk("cpu_busy",  32'(ifc.cpu_busy),  32'(n < exp_lat));
         chk("cpu_ready", 32'(ifc.cpu_ready), 32'(n == exp_lat));
         chk("rd_mem",    32'(ifc.rd_mem),    32'(rd_miss && n >= s + 1 && n <= s + int'(RDC)));
         chk("wr_mem",    32'(ifc.wr_mem),    32'(we && n == s + 1));
         if (ifc.rd_mem || ifc.wr_mem) chk("addr_mem", 32'(ifc.addr_mem), 32'(addr));
         if (ifc.wr_mem) chk("mem_data_wr", 32'(mem_bus), 32'(wdata));
         if (!we && n == exp_lat) chk("cpu_rdata", 32'(ifc.cpu_rdata), 32'(exp_rd));
      end

      if (hit) ref_hits++; else ref_misses++;
      if (we) begin
         ref_mem[addr] = wdata;
         if (hit) ref_data[idx] = wdata;
         chk("mem_written", 32'(tb_wflag[addr]), 32'd1);
         chk("mem_value",   32'(tb_mem[addr]),   32'(wdata));
      end else if (!hit) begin
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = tg;
         ref_data[idx]  = ref_mem[addr];
      end
   endtask

   // Read miss aborted by reset during its first MEM_RD cycle
   task automatic abort_read(input logic [AW-1:0] addr);
      ifc.cpu_req   = 1'b1;
      ifc.cpu_we    = 1'b0;
      ifc.cpu_addr  = addr;
      ifc.ready_mem = 1'b1;
      @(posedge clk); #1;
      ifc.cpu_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_rd_on", 32'(ifc.rd_mem), 32'd1);
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("abort_rd_off", 32'(ifc.rd_mem),    32'd0);
      chk("abort_wr_off", 32'(ifc.wr_mem),    32'd0);
      chk("abort_ready",  32'(ifc.cpu_ready), 32'd0);
      chk("abort_busy",   32'(ifc.cpu_busy),  32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_ready", 32'(ifc.cpu_ready), 32'd0);
         chk("abort_no_rd",    32'(ifc.rd_mem),    32'd0);
      end
      ref_invalidate();
   endtask

   initial begin
      for (int i = 0; i < int'(MEMSZ); i++) ref_mem[i] = init_val(AW'(i));
      ref_invalidate();

      // reset held with a pending request
      reset_n       = 1'b0;
      ifc.cpu_req   = 1'b1;
      ifc.cpu_we    = 1'b0;
      ifc.cpu_addr  = 9'h123;
      ifc.cpu_wdata = 8'h00;
      ifc.ready_mem = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_mem",    32'(ifc.rd_mem),    32'd0);
      chk("rst_wr_mem",    32'(ifc.wr_mem),    32'd0);
      chk("rst_cpu_ready", 32'(ifc.cpu_ready), 32'd0);
      chk("rst_cpu_busy",  32'(ifc.cpu_busy),  32'd0);
      chk("rst_addr_mem",  32'(ifc.addr_mem),  32'd0);
      chk("rst_cpu_rdata", 32'(ifc.cpu_rdata), 32'd0);
`ifdef CACHE_STATS_EN
      chk("rst_hit_count",  32'(ifc.hit_count),  32'd0);
      chk("rst_miss_count", 32'(ifc.miss_count), 32'd0);
`endif
      ifc.cpu_req = 1'b0;
      reset_n     = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 32'(ifc.cpu_busy), 32'd0);

      // directed scenarios
      do_access(1'b0, 9'h123, 8'h00, 0);   // cold miss -> A5
      do_access(1'b0, 9'h123, 8'h00, 1);   // hit
`ifdef CACHE_STATS_EN
      chk("stats_hit_2rd",  32'(ifc.hit_count),  32'd1);
      chk("stats_miss_2rd", 32'(ifc.miss_count), 32'd1);
`endif
      do_access(1'b1, 9'h123, 8'h5A, 0);   // write hit
      do_access(1'b0, 9'h123, 8'h00, 0);   // hit 5A
      do_access(1'b1, 9'h044, 8'h77, 2);   // write miss, no allocate
      do_access(1'b0, 9'h044, 8'h00, 0);   // read miss
      do_access(1'b0, 9'h023, 8'h00, 1);   // evicts 0x123
      do_access(1'b0, 9'h123, 8'h00, 3);   // misses again
      abort_read(9'h155);
      do_access(1'b0, 9'h155, 8'h00, 0);   // misses after abort
      do_access(1'b0, 9'h123, 8'h00, 0);   // cache empty after reset

      // randomized traffic, addresses biased toward few tags to force hits
      for (int t = 0; t < 200; t++) begin
         logic [AW-1:0] a;
         logic          w;
         if ($urandom_range(0, 3) == 0) a = AW'($urandom);
         else a = AW'(($urandom_range(0, 3) << IW) | $urandom_range(0, NL - 1));
         w = ($urandom_range(0, 2) == 0);
         do_access(w, a, DW'($urandom), int'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

`ifdef CACHE_STATS_EN
      chk("stats_hit_final",  32'(ifc.hit_count),  32'(ref_hits));
      chk("stats_miss_final", 32'(ifc.miss_count), 32'(ref_misses));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/direct_mapped_cache_ctrl.md
Name: direct_mapped_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller between the CPU-side requester and main memory.
- One data word per line.
- Drives the main-memory port (rd_mem, wr_mem, shared bidirectional data bus, addr_mem) and observes ready_mem.
- Hides memory latency on read hits; serialises all memory traffic.

Parameters:
- AWIDTH, 9, address width (CPU and memory).
- DWIDTH, 8, data width.
- IDX_W, 4, index bits; NUM_LINES = 2**IDX_W; tag width = AWIDTH-IDX_W.
- MEM_RD_CYC, 2, cycles rd_mem is held per memory read (min 2).

Ports:
- clk  in  1  clock, all state on posedge
- reset_n  in  1  synchronous, active-low reset
- cpu_req  in  1  request strobe, sampled only when cpu_busy=0
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  AWIDTH  request address
- cpu_wdata  in  DWIDTH  write data
- cpu_rdata  out  DWIDTH  read data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- cpu_busy  out  1  controller not in IDLE (combinational from state)
- rd_mem  out  1  memory read request
- wr_mem  out  1  memory write request
- mem_data  inout  DWIDTH  memory data bus; driven only while wr_mem=1, else high-Z
- addr_mem  out  AWIDTH  memory address
- ready_mem  in  1  memory idle indication

Behaviour:
- Reset (reset_n=0 at posedge):
  - State=IDLE; all valid bits cleared.
  - rd_mem=0, wr_mem=0, cpu_ready=0, cpu_rdata=0, addr_mem=0; mem_data high-Z.
- Address split: index=addr[IDX_W-1:0], tag=addr[AWIDTH-1:IDX_W].
- IDLE:
  - If cpu_req=1, latch addr/we/wdata and go to LOOKUP.
  - cpu_req while cpu_busy=1 is ignored; no queueing.
- LOOKUP: hit = valid[index] && tag_mem[index]==tag.
  - Read hit: cpu_rdata<=line, cpu_ready<=1, go to IDLE. cpu_ready is high in the 2nd cycle after the sampling edge.
  - Read miss or any write: stall in LOOKUP while ready_mem=0. Otherwise load addr_mem, then:
    - read: rd_mem<=1, go to MEM_RD;
    - write: wr_mem<=1, go to MEM_WR.
  - Write hit: the line data is updated in this cycle. Write miss leaves the cache array untouched.
- MEM_RD:
  - rd_mem held for exactly MEM_RD_CYC cycles, with a counter.
  - On the final cycle's edge: capture mem_data into line[index]; set tag and valid; cpu_rdata<=mem_data; cpu_ready<=1; rd_mem<=0; go to IDLE.
- MEM_WR:
  - wr_mem held for exactly 1 cycle with mem_data=latched wdata and addr_mem stable.
  - Next edge: wr_mem<=0, cpu_ready<=1, go to IDLE.
- Output rules:
  - rd_mem and wr_mem are never both 1.
  - addr_mem is stable for the whole rd_mem/wr_mem window.
  - cpu_ready is never high for more than one cycle.
- Conflict miss: a read miss to an occupied index overwrites the line. No write-back is needed (write-through).
- Reset mid-transaction: return to IDLE on the next edge. rd_mem/wr_mem drop, the bus is released, no cpu_ready is issued for the aborted request, and all lines are invalid.
- Any undefined state recovers to IDLE.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0], both reset to 0.
  - Incremented once per lookup that leaves LOOKUP (read hit, read miss, write hit, write miss respectively). A stalled LOOKUP is not counted repeatedly.
  - Counters saturate at 16'hFFFF.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset with cpu_req=1 held → after release: rd_mem=wr_mem=cpu_ready=0, mem_data=Z, cpu_busy=0. The first read to any address misses.
- Cold read 0x123, memory[0x123]=0xA5 → addr_mem=0x123, rd_mem=1 for exactly 2 cycles, then cpu_ready pulse with cpu_rdata=0xA5.
- Repeat read 0x123 → no rd_mem; cpu_ready 2 cycles after request with 0xA5.
- Write 0x123 data 0x5A:
  - wr_mem=1 for one cycle, mem_data=0x5A, then cpu_ready.
  - Memory[0x123]=0x5A.
  - Subsequent read 0x123 hits with 0x5A.
- Write miss to 0x044 data 0x77 → memory updated, no allocation; read 0x044 misses. Read 0x023 (index 3, tag 0x02) evicts 0x123; a later read of 0x123 misses again.
- reset_n=0 during 1st MEM_RD cycle → rd_mem=0 next cycle, no cpu_ready. A subsequent read of the same address misses.
- With CACHE_STATS_EN, the first two reads (miss, then hit) produce hit_count=1, miss_count=1.
